hdmi_config_sequencer: RTL and testbench

HDMI_CONFIG_SEQUENCER -- requirements
Module: hdmi_config_sequencer

---
 rtl/hdmi_config_sequencer_pkg.sv | 50 +++++
 rtl/hdmi_config_rom.sv | 16 +
 rtl/hdmi_config_sequencer.sv | 174 +++++++++++++++++
 tb/tb_hdmi_config_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_config_sequencer_pkg.sv
// Shared definitions for the HDMI transmitter configuration sequencer:
// state encoding, table end marker, retry gap and the register tables.
package hdmi_config_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PWR_WAIT,
    FETCH,
    ISSUE,
    WAIT_DONE,
    RETRY,
    DONE,
    ERROR
  } state_t;

  localparam logic [15:0] END_MARKER = 16'hFFFF;
  localparam int RETRY_GAP = 16;

  // Table 0 is the transmitter bring-up set; 1 and 2 are short bring-up/bypass tables.
  function automatic logic [15:0] rom_entry(input int table_sel, input logic [7:0] idx);
    logic [15:0] e;
    e = END_MARKER;
    if (table_sel == 1) begin
      case (idx)
        8'd0: e = 16'h4110;
        8'd1: e = 16'h9803;
        8'd2: e = 16'hAF06;
        default: e = END_MARKER;
      endcase
    end else if (table_sel == 0) begin
      case (idx)
        8'd0:  e = 16'h4110;
        8'd1:  e = 16'h9803;
        8'd2:  e = 16'h9AE0;
        8'd3:  e = 16'h9C30;
        8'd4:  e = 16'h9D61;
        8'd5:  e = 16'hA2A4;
        8'd6:  e = 16'hA3A4;
        8'd7:  e = 16'hE0D0;
        8'd8:  e = 16'hF900;
        8'd9:  e = 16'h1500;
        8'd10: e = 16'h1630;
        8'd11: e = 16'hAF06;
        default: e = END_MARKER;
      endcase
    end
    return e;
  endfunction

endpackage

// File: rtl/hdmi_config_rom.sv
// Synchronous configuration ROM: {register, data} per index, one-cycle read latency.
module hdmi_config_rom
  import hdmi_config_sequencer_pkg::*;
#(
  parameter int TABLE_SEL = 0
) (
  input  logic        clk,
  input  logic [7:0]  addr,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    q <= rom_entry(TABLE_SEL, addr);
  end

endmodule

// File: rtl/hdmi_config_sequencer.sv
// Walks the configuration ROM and issues one I2C register write per entry,
// retrying on NACK/timeout and restarting on configStart or hot-plug.
module hdmi_config_sequencer
  import hdmi_config_sequencer_pkg::*;
#(
  parameter logic [7:0] SLAVE_ADDR   = 8'h72,
  parameter int         NUM_ENTRIES  = 32,
  parameter int         MAX_RETRIES  = 3,
  parameter int         POWERUP_WAIT = 40000,
  parameter int         TIMEOUT      = 1024,
  parameter int         TABLE_SEL    = 0
) (
  input  logic       clockIn,
  input  logic       reset,
  input  logic       configStart,
  input  logic       hpd,
  output logic       i2cStart,
  output logic [7:0] slaveAddress,
  output logic [7:0] dataAddress,
  output logic [7:0] data,
  input  logic       i2cDone,
  input  logic       i2cAck,
  output logic       configDone,
  output logic       configError,
  output logic [7:0] errorIndex
);

  localparam logic [7:0]  LAST_IDX = 8'(NUM_ENTRIES - 1);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRIES);
  localparam logic [31:0] PWR_LAST = 32'(POWERUP_WAIT - 1);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
  localparam logic [31:0] GAP_LAST = 32'(RETRY_GAP - 1);

  state_t      state;
  logic [7:0]  entry_idx;
  logic [7:0]  retries;
  logic [31:0] wait_cnt;
  logic        fetch_ready;
  logic        hpd_lost;
  logic [15:0] rom_q;
  logic        hpd_meta, hpd_sync, hpd_prev, start_prev;
  logic        hpd_rise, hpd_fall, trigger, hpd_gone;

  hdmi_config_rom #(.TABLE_SEL(TABLE_SEL)) u_rom (
    .clk  (clockIn),
    .addr (entry_idx),
    .q    (rom_q)
  );

  assign slaveAddress = SLAVE_ADDR;
  assign hpd_rise = hpd_sync & ~hpd_prev;
  assign hpd_fall = ~hpd_sync & hpd_prev;
  // An hpd fall in the same cycle as any trigger always wins.
  assign trigger  = (hpd_rise | (configStart & ~start_prev)) & ~hpd_fall;
  assign hpd_gone = hpd_lost | hpd_fall;

  always_ff @(posedge clockIn or posedge reset) begin
    if (reset) begin
      hpd_meta   <= 1'b0;
      hpd_sync   <= 1'b0;
      hpd_prev   <= 1'b0;
      start_prev <= 1'b0;
    end else begin
      hpd_meta   <= hpd;
      hpd_sync   <= hpd_meta;
      hpd_prev   <= hpd_sync;
      start_prev <= configStart;
    end
  end

  always_ff @(posedge clockIn or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      entry_idx   <= 8'h00;
      retries     <= 8'h00;
      wait_cnt    <= 32'd0;
      fetch_ready <= 1'b0;
      hpd_lost    <= 1'b0;
      i2cStart    <= 1'b0;
      dataAddress <= 8'h00;
      data        <= 8'h00;
      configDone  <= 1'b0;
      configError <= 1'b0;
      errorIndex  <= 8'h00;
    end else begin
      i2cStart <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (trigger) begin
            state       <= PWR_WAIT;
            entry_idx   <= 8'h00;
            retries     <= 8'h00;
            wait_cnt    <= 32'd0;
            hpd_lost    <= 1'b0;
            configDone  <= 1'b0;
            configError <= 1'b0;
          end
        end
        PWR_WAIT: begin
          if (hpd_fall) begin
            state <= IDLE;
          end else if (wait_cnt == PWR_LAST) begin
            state       <= FETCH;
            fetch_ready <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        FETCH: begin
          if (hpd_fall) begin
            state <= IDLE;
          end else if (!fetch_ready) begin
            fetch_ready <= 1'b1;
          end else if (rom_q == END_MARKER) begin
            state      <= DONE;
            configDone <= 1'b1;
          end else begin
            dataAddress <= rom_q[15:8];
            data        <= rom_q[7:0];
            i2cStart    <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (hpd_fall) hpd_lost <= 1'b1;
          wait_cnt <= 32'd0;
          state    <= WAIT_DONE;
        end
        // The bus transfer always completes; an hpd loss is acted on afterwards.
        WAIT_DONE: begin
          if (i2cDone || wait_cnt == TO_LAST) begin
            wait_cnt <= 32'd0;
            if (hpd_gone) begin
              state <= IDLE;
            end else if (i2cDone && i2cAck) begin
              retries <= 8'h00;
              if (entry_idx == LAST_IDX) begin
                state      <= DONE;
                configDone <= 1'b1;
              end else begin
                entry_idx   <= entry_idx + 8'h01;
                fetch_ready <= 1'b0;
                state       <= FETCH;
              end
            end else begin
              state <= RETRY;
            end
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
            if (hpd_fall) hpd_lost <= 1'b1;
          end
        end
        RETRY: begin
          if (hpd_fall) begin
            state <= IDLE;
          end else if (retries >= RETRY_MAX) begin
            errorIndex  <= entry_idx;
            configError <= 1'b1;
            state       <= ERROR;
          end else if (wait_cnt == GAP_LAST) begin
            retries  <= retries + 8'h01;
            wait_cnt <= 32'd0;
            i2cStart <= 1'b1;
            state    <= ISSUE;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_config_sequencer.sv
// Scoreboard bench: expected writes and I2C responses are queued with each
// stimulus and consumed by a responder that models the I2C master.
module tb_hdmi_config_sequencer;

  localparam int PW  = 20;
  localparam int TO  = 40;
  localparam int GAP = 16;

  logic       clockIn = 1'b0;
  logic       reset, config_start, hpd, i2c_done, i2c_ack;
  logic       i2c_start, config_done, config_error;
  logic [7:0] slave_address, data_address, data, error_index;

  logic       aux_start, aux_hpd;
  logic       bd_start, bd_done, bd_ack, bd_cfg_done, bd_cfg_err;
  logic [7:0] bd_slave, bd_addr, bd_data, bd_err_idx;
  logic       em_start, em_done, em_ack, em_cfg_done, em_cfg_err;
  logic [7:0] em_slave, em_addr, em_data, em_err_idx;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_count = 0;
  int last_stamp = 0;
  int prev_stamp = 0;
  int trig_cyc = 0;
  int done_cyc = 0;
  int bd_count = 0;
  int em_count = 0;
  logic [15:0] bd_last = 16'h0000;

  logic [15:0] exp_q[$];
  int          resp_q[$];
  logic [15:0] tbl [3] = '{16'h4110, 16'h9803, 16'hAF06};

  always #5 clockIn = ~clockIn;

  hdmi_config_sequencer #(.NUM_ENTRIES(32), .MAX_RETRIES(3), .POWERUP_WAIT(PW),
                          .TIMEOUT(TO), .TABLE_SEL(1)) dut (
    .clockIn(clockIn), .reset(reset), .configStart(config_start), .hpd(hpd),
    .i2cStart(i2c_start), .slaveAddress(slave_address), .dataAddress(data_address),
    .data(data), .i2cDone(i2c_done), .i2cAck(i2c_ack), .configDone(config_done),
    .configError(config_error), .errorIndex(error_index));

  hdmi_config_sequencer #(.NUM_ENTRIES(2), .POWERUP_WAIT(PW), .TIMEOUT(TO),
                          .TABLE_SEL(0)) dut_bound (
    .clockIn(clockIn), .reset(reset), .configStart(aux_start), .hpd(aux_hpd),
    .i2cStart(bd_start), .slaveAddress(bd_slave), .dataAddress(bd_addr),
    .data(bd_data), .i2cDone(bd_done), .i2cAck(bd_ack), .configDone(bd_cfg_done),
    .configError(bd_cfg_err), .errorIndex(bd_err_idx));

  hdmi_config_sequencer #(.POWERUP_WAIT(PW), .TIMEOUT(TO), .TABLE_SEL(2)) dut_empty (
    .clockIn(clockIn), .reset(reset), .configStart(aux_start), .hpd(aux_hpd),
    .i2cStart(em_start), .slaveAddress(em_slave), .dataAddress(em_addr),
    .data(em_data), .i2cDone(em_done), .i2cAck(em_ack), .configDone(em_cfg_done),
    .configError(em_cfg_err), .errorIndex(em_err_idx));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Response codes: 0 ack, 1 nack, 2 no i2cDone, 3 slow ack.
  task automatic expectTxn(input int idx, input int code);
    exp_q.push_back(tbl[idx]);
    resp_q.push_back(code);
  endtask

  task automatic applyStimulus(input bit via_hpd);
    @(negedge clockIn);
    trig_cyc = cyc;
    if (via_hpd) begin
      hpd = 1'b1;
    end else begin
      config_start = 1'b1;
      repeat (2) @(negedge clockIn);
      config_start = 1'b0;
    end
  endtask

  task automatic waitStarts(input int target, input int budget);
    for (int i = 0; i < budget && start_count < target; i++) @(negedge clockIn);
    checkOutput("start_seen", start_count >= target, 1);
  endtask

  task automatic waitResult(input int budget);
    repeat (5) @(negedge clockIn);
    for (int i = 0; i < budget && !(config_done || config_error); i++) @(negedge clockIn);
    done_cyc = cyc;
    checkOutput("finished_in_budget", config_done | config_error, 1);
  endtask

  initial forever begin
    @(posedge clockIn);
    cyc++;
  end

  initial begin
    logic [15:0] e;
    int code;
    i2c_done = 1'b0;
    i2c_ack  = 1'b0;
    forever begin
      @(negedge clockIn);
      if (i2c_start) begin
        start_count++;
        prev_stamp = last_stamp;
        last_stamp = cyc;
        checkOutput("start_expected", exp_q.size() != 0, 1);
        e = 16'h0000;
        code = 0;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        if (resp_q.size() != 0) code = resp_q.pop_front();
        checkOutput("slave", slave_address, 8'h72);
        checkOutput("reg", data_address, e[15:8]);
        checkOutput("data", data, e[7:0]);
        @(negedge clockIn);
        checkOutput("start_width", i2c_start, 0);
        if (code != 2) begin
          repeat ((code == 3) ? 20 : 3) @(negedge clockIn);
          checkOutput("reg_stable", data_address, e[15:8]);
          i2c_ack  = (code == 0 || code == 3);
          i2c_done = 1'b1;
          @(negedge clockIn);
          i2c_done = 1'b0;
          i2c_ack  = 1'b0;
        end
      end
    end
  end

  initial begin
    bd_done = 1'b0;
    bd_ack  = 1'b0;
    forever begin
      @(negedge clockIn);
      if (bd_start) begin
        bd_count++;
        bd_last = {bd_addr, bd_data};
        repeat (3) @(negedge clockIn);
        bd_ack  = 1'b1;
        bd_done = 1'b1;
        @(negedge clockIn);
        bd_done = 1'b0;
        bd_ack  = 1'b0;
      end
    end
  end

  initial begin
    em_done = 1'b0;
    em_ack  = 1'b0;
    forever begin
      @(negedge clockIn);
      if (em_start) begin
        em_count++;
        repeat (3) @(negedge clockIn);
        em_ack  = 1'b1;
        em_done = 1'b1;
        @(negedge clockIn);
        em_done = 1'b0;
        em_ack  = 1'b0;
      end
    end
  end

  initial begin
    int base;
    reset = 1'b1;
    config_start = 1'b0;
    hpd = 1'b0;
    aux_start = 1'b0;
    aux_hpd = 1'b0;
    repeat (3) @(negedge clockIn);
    checkOutput("rst_start", i2c_start, 0);
    checkOutput("rst_reg", data_address, 8'h00);
    checkOutput("rst_data", data, 8'h00);
    checkOutput("rst_err_idx", error_index, 8'h00);
    checkOutput("rst_done", config_done, 0);
    checkOutput("rst_error", config_error, 0);
    reset = 1'b0;
    repeat (3) @(negedge clockIn);

    $display("[TB] three entries, all acked, with a mid-pass retrigger");
    base = start_count;
    expectTxn(0, 0); expectTxn(1, 0); expectTxn(2, 0);
    applyStimulus(1'b0);
    repeat (PW - 5) @(negedge clockIn);
    checkOutput("quiet_power_wait", start_count - base, 0);
    checkOutput("done_low_in_pass", config_done, 0);
    waitStarts(base + 2, 200);
    config_start = 1'b1;
    repeat (2) @(negedge clockIn);
    config_start = 1'b0;
    waitResult(300);
    checkOutput("s1_done", config_done, 1);
    checkOutput("s1_error", config_error, 0);
    checkOutput("s1_count", start_count - base, 3);
    checkOutput("s1_latency", (done_cyc - trig_cyc >= PW + 9) && (done_cyc - trig_cyc <= PW + 60), 1);
    checkOutput("s1_leftover", exp_q.size(), 0);

    $display("[TB] entry 1 nacked twice then acked");
    base = start_count;
    expectTxn(0, 0); expectTxn(1, 1); expectTxn(1, 1); expectTxn(1, 0); expectTxn(2, 0);
    applyStimulus(1'b0);
    waitResult(500);
    checkOutput("s2_done", config_done, 1);
    checkOutput("s2_error", config_error, 0);
    checkOutput("s2_count", start_count - base, 5);

    $display("[TB] entry 2 always nacked");
    base = start_count;
    expectTxn(0, 0); expectTxn(1, 0);
    for (int i = 0; i < 4; i++) expectTxn(2, 1);
    applyStimulus(1'b0);
    waitResult(600);
    checkOutput("s3_error", config_error, 1);
    checkOutput("s3_done", config_done, 0);
    checkOutput("s3_err_idx", error_index, 8'h02);
    checkOutput("s3_count", start_count - base, 6);

    $display("[TB] no i2cDone at all");
    base = start_count;
    for (int i = 0; i < 4; i++) expectTxn(0, 2);
    applyStimulus(1'b0);
    waitResult(600);
    checkOutput("s4_error", config_error, 1);
    checkOutput("s4_err_idx", error_index, 8'h00);
    checkOutput("s4_count", start_count - base, 4);
    checkOutput("s4_retry_gap", last_stamp - prev_stamp, TO + GAP + 1);

    $display("[TB] hpd drops during a transfer, then returns");
    base = start_count;
    expectTxn(0, 3);
    applyStimulus(1'b1);
    waitStarts(base + 1, 200);
    hpd = 1'b0;
    repeat (60) @(negedge clockIn);
    checkOutput("s5_abort_count", start_count - base, 1);
    checkOutput("s5_abort_done", config_done, 0);
    checkOutput("s5_abort_error", config_error, 0);
    expectTxn(0, 0); expectTxn(1, 0); expectTxn(2, 0);
    applyStimulus(1'b1);
    waitResult(300);
    checkOutput("s5_done", config_done, 1);
    checkOutput("s5_count", start_count - base, 4);
    hpd = 1'b0;
    repeat (5) @(negedge clockIn);

    $display("[TB] empty table and entry-count bound");
    aux_start = 1'b1;
    repeat (2) @(negedge clockIn);
    aux_start = 1'b0;
    for (int i = 0; i < 300 && !(bd_cfg_done && em_cfg_done); i++) @(negedge clockIn);
    checkOutput("empty_done", em_cfg_done, 1);
    checkOutput("empty_count", em_count, 0);
    checkOutput("bound_done", bd_cfg_done, 1);
    checkOutput("bound_error", bd_cfg_err, 0);
    checkOutput("bound_count", bd_count, 2);
    checkOutput("bound_last", bd_last, 16'h9803);

    $display("[TB] reset during a transfer");
    base = start_count;
    expectTxn(0, 2);
    applyStimulus(1'b0);
    waitStarts(base + 1, 200);
    @(negedge clockIn);
    reset = 1'b1;
    #1;
    checkOutput("midrst_start", i2c_start, 0);
    checkOutput("midrst_reg", data_address, 8'h00);
    checkOutput("midrst_done", config_done, 0);
    @(negedge clockIn);
    reset = 1'b0;
    repeat (80) @(negedge clockIn);
    checkOutput("midrst_idle_count", start_count - base, 1);
    checkOutput("midrst_idle_done", config_done, 0);
    checkOutput("midrst_idle_error", config_error, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
